// File: rtl/mem_stage_sram_if.sv
// Pipeline and SRAM signals of the memory stage, grouped for the stage boundary.
interface mem_stage_sram_if #(
   parameter int unsigned ADDR_W = 16
);
   // From EXE2MEM
   logic              wb_en_in;
   logic              mem_read_in;
   logic              mem_write_in;
   logic [3:0]        dest_in;
   logic [31:0]       alu_result_in;
   logic [31:0]       st_val_in;
   // Pipeline freeze
   logic              ready;
   // SRAM
   logic [ADDR_W-1:0] sram_addr;
   logic [31:0]       sram_dq_out;
   logic [31:0]       sram_dq_in;
   logic              sram_we_n;
   logic              sram_oe_n;
   // To WB
   logic              wb_en_out;
   logic              mem_read_out;
   logic [3:0]        dest_out;
   logic [31:0]       alu_result_out;
   logic [31:0]       mem_data_out;

   // Memory stage view
   modport slave (
      input  wb_en_in, mem_read_in, mem_write_in, dest_in, alu_result_in, st_val_in,
      input  sram_dq_in,
      output ready,
      output sram_addr, sram_dq_out, sram_we_n, sram_oe_n,
      output wb_en_out, mem_read_out, dest_out, alu_result_out, mem_data_out
   );

   // Pipeline / SRAM environment view
   modport master (
      output wb_en_in, mem_read_in, mem_write_in, dest_in, alu_result_in, st_val_in,
      output sram_dq_in,
      input  ready,
      input  sram_addr, sram_dq_out, sram_we_n, sram_oe_n,
      input  wb_en_out, mem_read_out, dest_out, alu_result_out, mem_data_out
   );
endinterface

// File: rtl/mem_stage_sram.sv
// Memory stage with wait-stated SRAM access and the MEM/WB pipeline register.
module mem_stage_sram #(
   parameter int unsigned WAIT_STATES = 3,
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned BASE_ADDR   = 1024
) (
   input  logic            clk,
   input  logic            rst,
   mem_stage_sram_if.slave bus
);
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned DEST_W = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   rbuf_q, rbuf_d;

   logic                wb_en_q;
   logic                mem_read_q;
   logic [DEST_W-1:0]   dest_q;
   logic [DATA_W-1:0]   alu_result_q;
   logic [DATA_W-1:0]   mem_data_q;

   logic                is_store;
   logic                is_load;
   logic                req;
   logic                last_beat;
   logic                ready_c;
   logic                we_n_c;
   logic                oe_n_c;

   // Request decode; a store wins over a simultaneous load
   assign is_store  = bus.mem_write_in;
   assign is_load   = bus.mem_read_in & ~bus.mem_write_in;
   assign req       = bus.mem_read_in | bus.mem_write_in;
   assign last_beat = (cnt_q == CNT_W'(WAIT_STATES));

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req) state_d = ACCESS;
         ACCESS:  if (last_beat) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Per-state outputs: freeze, SRAM strobes, wait counter and read capture
   always_comb begin
      ready_c = 1'b1;
      we_n_c  = 1'b1;
      oe_n_c  = 1'b1;
      cnt_d   = '0;
      rbuf_d  = rbuf_q;
      case (state_q)
         IDLE: ready_c = ~req;
         ACCESS: begin
            ready_c = 1'b0;
            we_n_c  = ~is_store;
            oe_n_c  = ~is_load;
            cnt_d   = cnt_q + CNT_W'(1);
            if (last_beat && is_load) rbuf_d = bus.sram_dq_in;
         end
         DONE: ready_c = 1'b1;
         default: ready_c = 1'b1;
      endcase
      // While reset is held the pipeline is released and no strobe may fire
      if (!rst) begin
         ready_c = 1'b1;
         we_n_c  = 1'b1;
         oe_n_c  = 1'b1;
      end
   end

   // Wait counter and read buffer
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q  <= '0;
         rbuf_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         rbuf_q <= rbuf_d;
      end
   end

   // MEM/WB register: advance when ready, otherwise insert a bubble
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_en_q      <= 1'b0;
         mem_read_q   <= 1'b0;
         dest_q       <= '0;
         alu_result_q <= '0;
         mem_data_q   <= '0;
      end else if (ready_c) begin
         wb_en_q      <= bus.wb_en_in;
         mem_read_q   <= is_load;
         dest_q       <= bus.dest_in;
         alu_result_q <= bus.alu_result_in;
         if ((state_q == DONE) && is_load) mem_data_q <= rbuf_q;
      end else begin
         wb_en_q    <= 1'b0;
         mem_read_q <= 1'b0;
      end
   end

   assign bus.ready          = ready_c;
   assign bus.sram_addr      = ADDR_W'((bus.alu_result_in - DATA_W'(BASE_ADDR)) >> 2);
   assign bus.sram_dq_out    = bus.st_val_in;
   assign bus.sram_we_n      = we_n_c;
   assign bus.sram_oe_n      = oe_n_c;
   assign bus.wb_en_out      = wb_en_q;
   assign bus.mem_read_out   = mem_read_q;
   assign bus.dest_out       = dest_q;
   assign bus.alu_result_out = alu_result_q;
   assign bus.mem_data_out   = mem_data_q;

endmodule

// File: tb/tb_mem_stage_sram.sv
// Self-checking bench for mem_stage_sram: directed table, reset corner case, random stream.
module tb_mem_stage_sram;
   localparam int unsigned WS     = 3;
   localparam int unsigned BASE   = 1024;
   localparam int unsigned N_RAND = 40;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   mem_stage_sram_if #(.ADDR_W(16)) bus ();

   mem_stage_sram #(.WAIT_STATES(WS), .ADDR_W(16), .BASE_ADDR(BASE)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // External SRAM: writes on the rising edge, read data presented mid-cycle
   logic [31:0] sram_mem [0:65535];
   always @(posedge clk) begin
      if (!bus.sram_we_n) sram_mem[bus.sram_addr] <= bus.sram_dq_out;
   end
   always @(negedge clk) begin
      bus.sram_dq_in <= bus.sram_oe_n ? 32'h0 : sram_mem[bus.sram_addr];
   end

   // Reference model: word memory keyed by word index, plus last loaded value
   logic [31:0] ref_mem [int unsigned];
   logic [31:0] model_data = 32'h0;

   function automatic int unsigned word_of(input logic [31:0] a);
      int unsigned d;
      d = a - BASE;
      return (d / 4) % 65536;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic        wb;
      logic        rd;
      logic        wr;
      logic [3:0]  dest;
      logic [31:0] alu;
      logic [31:0] st;
      int          rdy_low;
      int          we_low;
      int          oe_low;
      logic [15:0] addr;
      logic        mrd;
      logic [31:0] data;
   } vec_t;

   // Apply one instruction (called just after a rising edge) and check it through retirement
   task automatic run(input vec_t v);
      int   rdy_low, we_low, oe_low;
      logic addr_ok, bubble_ok, done;
      int unsigned w;
      bus.wb_en_in      = v.wb;
      bus.mem_read_in   = v.rd;
      bus.mem_write_in  = v.wr;
      bus.dest_in       = v.dest;
      bus.alu_result_in = v.alu;
      bus.st_val_in     = v.st;
      rdy_low = 0; we_low = 0; oe_low = 0;
      addr_ok = 1'b1; bubble_ok = 1'b1; done = 1'b0;
      for (int cyc = 0; cyc < 64; cyc++) begin
         @(negedge clk);
         if (!bus.ready) rdy_low++;
         if (!bus.sram_we_n) begin
            we_low++;
            if (bus.sram_addr !== v.addr || bus.sram_dq_out !== v.st) addr_ok = 1'b0;
         end
         if (!bus.sram_oe_n) begin
            oe_low++;
            if (bus.sram_addr !== v.addr) addr_ok = 1'b0;
         end
         if (cyc > 0 && bus.wb_en_out !== 1'b0) bubble_ok = 1'b0;
         if (bus.ready) begin
            done = 1'b1;
            break;
         end
      end
      chk("ready_returns", 32'(done), 32'd1);
      chk("ready_low_cycles", 32'(rdy_low), 32'(v.rdy_low));
      chk("we_low_cycles", 32'(we_low), 32'(v.we_low));
      chk("oe_low_cycles", 32'(oe_low), 32'(v.oe_low));
      if (v.we_low + v.oe_low > 0) chk("sram_addr_data", 32'(addr_ok), 32'd1);
      if (v.rdy_low > 0) chk("stall_bubble", 32'(bubble_ok), 32'd1);
      @(posedge clk);
      #1;
      chk("wb_en_out", 32'(bus.wb_en_out), 32'(v.wb));
      chk("mem_read_out", 32'(bus.mem_read_out), 32'(v.mrd));
      chk("dest_out", 32'(bus.dest_out), 32'(v.dest));
      chk("alu_result_out", bus.alu_result_out, v.alu);
      chk("mem_data_out", bus.mem_data_out, v.data);
      w = word_of(v.alu);
      if (v.wr) ref_mem[w] = v.st;
      else if (v.rd) model_data = ref_mem.exists(w) ? ref_mem[w] : 32'h0;
   endtask

   vec_t        tbl [8];
   vec_t        rv;
   int unsigned op, w;

   initial begin
      bus.wb_en_in = 0; bus.mem_read_in = 0; bus.mem_write_in = 0;
      bus.dest_in = 0; bus.alu_result_in = 0; bus.st_val_in = 0;

      // Directed vectors: {wb, rd, wr, dest, alu, st, ready_low, we_low, oe_low, addr, mem_read_out, mem_data_out}
      tbl[0] = '{1'b1, 1'b0, 1'b0, 4'd5, 32'h1234,          32'h0,        0, 0, 0, 16'd0, 1'b0, 32'h0};
      tbl[1] = '{1'b0, 1'b0, 1'b1, 4'd2, 32'd1028,          32'hDEADBEEF, 5, 4, 0, 16'd1, 1'b0, 32'h0};
      tbl[2] = '{1'b1, 1'b1, 1'b0, 4'd3, 32'd1028,          32'h0,        5, 0, 4, 16'd1, 1'b1, 32'hDEADBEEF};
      tbl[3] = '{1'b0, 1'b1, 1'b1, 4'd6, 32'd1024,          32'hCAFEF00D, 5, 4, 0, 16'd0, 1'b0, 32'hDEADBEEF};
      tbl[4] = '{1'b1, 1'b1, 1'b0, 4'd8, 32'd1024,          32'h0,        5, 0, 4, 16'd0, 1'b1, 32'hCAFEF00D};
      tbl[5] = '{1'b0, 1'b0, 1'b1, 4'd1, 32'd1024 + 262144, 32'h11112222, 5, 4, 0, 16'd0, 1'b0, 32'hCAFEF00D};
      tbl[6] = '{1'b1, 1'b1, 1'b0, 4'd4, 32'd1027,          32'h0,        5, 0, 4, 16'd0, 1'b1, 32'h11112222};
      tbl[7] = '{1'b1, 1'b0, 1'b0, 4'd9, 32'hFFFF0000,      32'h0,        0, 0, 0, 16'd0, 1'b0, 32'h11112222};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", 32'(bus.ready), 32'd1);
      chk("rst_we_n", 32'(bus.sram_we_n), 32'd1);
      chk("rst_oe_n", 32'(bus.sram_oe_n), 32'd1);
      chk("rst_wb_en_out", 32'(bus.wb_en_out), 32'd0);
      chk("rst_alu_result_out", bus.alu_result_out, 32'h0);
      chk("rst_mem_data_out", bus.mem_data_out, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      foreach (tbl[i]) run(tbl[i]);

      // Reset during the second ACCESS cycle of a store
      bus.wb_en_in = 1; bus.mem_read_in = 0; bus.mem_write_in = 1;
      bus.dest_in = 4'd7; bus.alu_result_in = 32'd1024 + 20; bus.st_val_in = 32'hBAD0BAD0;
      repeat (3) @(negedge clk);
      chk("mid_we_before_rst", 32'(bus.sram_we_n), 32'd0);
      rst = 1'b0;
      #1;
      chk("mid_we_n", 32'(bus.sram_we_n), 32'd1);
      chk("mid_oe_n", 32'(bus.sram_oe_n), 32'd1);
      chk("mid_ready", 32'(bus.ready), 32'd1);
      chk("mid_wb_en_out", 32'(bus.wb_en_out), 32'd0);
      chk("mid_mem_read_out", 32'(bus.mem_read_out), 32'd0);
      chk("mid_dest_out", 32'(bus.dest_out), 32'd0);
      chk("mid_alu_result_out", bus.alu_result_out, 32'h0);
      chk("mid_mem_data_out", bus.mem_data_out, 32'h0);
      @(posedge clk);
      #1;
      chk("mid_we_n_held", 32'(bus.sram_we_n), 32'd1);
      bus.mem_write_in = 0;
      model_data = 32'h0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rv = '{1'b1, 1'b0, 1'b0, 4'd4, 32'h55AA, 32'h0, 0, 0, 0, 16'd0, 1'b0, 32'h0};
      run(rv);

      // Random stream against the reference model
      for (int k = 0; k < N_RAND; k++) begin
         op = $urandom_range(0, 3);
         w  = $urandom_range(0, 7);
         if (op == 1 && !ref_mem.exists(w)) op = 2;
         rv.wb   = 1'($urandom);
         rv.dest = 4'($urandom);
         rv.st   = $urandom;
         rv.rd   = (op == 1 || op == 3);
         rv.wr   = (op == 2 || op == 3);
         if (op == 0) rv.alu = $urandom;
         else rv.alu = BASE + 4 * w + $urandom_range(0, 3) + ($urandom_range(0, 1) != 0 ? 32'd262144 : 32'd0);
         rv.addr    = 16'(word_of(rv.alu));
         rv.rdy_low = (op == 0) ? 0 : int'(WS) + 2;
         rv.we_low  = rv.wr ? int'(WS) + 1 : 0;
         rv.oe_low  = (rv.rd && !rv.wr) ? int'(WS) + 1 : 0;
         rv.mrd     = rv.rd && !rv.wr;
         rv.data    = rv.mrd ? ref_mem[word_of(rv.alu)] : model_data;
         run(rv);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/mem_stage_sram.md
Name: mem_stage_sram

Overview:
- Memory stage of the pipelined ARM CPU. Sits between the EXE2MEM register and the WB stage.
- Performs LDR/STR accesses to an external word-wide SRAM that needs a fixed number of wait states.
- Stalls the pipeline with `ready` while an access is in flight.
- Contains the MEM/WB pipeline register, so all outputs toward WB are registered.

Parameters:
- WAIT_STATES, 3, extra SRAM cycles per access beyond the first; legal range 1..15.
- ADDR_W, 16, SRAM word-address width.
- BASE_ADDR, 1024, byte address that maps to SRAM word 0.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- wb_en_in  in  1  write-back enable, from EXE2MEM.
- mem_read_in  in  1  load request.
- mem_write_in  in  1  store request.
- dest_in  in  4  destination register index.
- alu_result_in  in  32  ALU result; this is the byte address for loads and stores.
- st_val_in  in  32  store data.
- ready  out  1  1 means the stage can accept a new instruction; 0 freezes IF/ID/EXE and EXE2MEM.
- sram_addr  out  ADDR_W  SRAM word address.
- sram_dq_out  out  32  SRAM write data.
- sram_dq_in  in  32  SRAM read data.
- sram_we_n  out  1  SRAM write enable, active low.
- sram_oe_n  out  1  SRAM output enable, active low.
- wb_en_out  out  1  registered write-back enable, to WB.
- mem_read_out  out  1  registered load flag; selects mem_data_out over alu_result_out in WB.
- dest_out  out  4  registered destination register index.
- alu_result_out  out  32  registered ALU result.
- mem_data_out  out  32  registered load data.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE and the wait counter clears.
  - All registered outputs are 0.
  - sram_we_n=1, sram_oe_n=1.
  - An access in progress is abandoned with no SRAM write strobe.
- Address mapping: sram_addr = ((alu_result_in - BASE_ADDR) >> 2) truncated to ADDR_W. The low 2 address bits are ignored (no misalignment trap). Out-of-range addresses wrap modulo 2^ADDR_W.
- Priority: a write takes priority when mem_write_in and mem_read_in are both 1; the read is dropped and mem_read_out=0.
- FSM states and transitions:
  - IDLE:
    - No memory request: ready=1 (combinational). The MEM/WB register loads the inputs on the next edge, with mem_data_out unchanged. Latency is 1 cycle.
    - Request present: ready=0 combinationally in the same cycle, counter cleared, go to ACCESS.
  - ACCESS:
    - ready=0; sram_addr and sram_dq_out are driven from the inputs, which the freeze holds stable.
    - Store: sram_we_n=0 in every ACCESS cycle.
    - Load: sram_oe_n=0 in every ACCESS cycle.
    - The counter increments each cycle. When counter==WAIT_STATES, capture sram_dq_in (loads only) into an internal read buffer and go to DONE.
    - Total ACCESS duration is WAIT_STATES+1 cycles.
  - DONE:
    - ready=1, SRAM strobes deasserted.
    - On the edge, the MEM/WB register loads the inputs, and mem_data_out loads the read buffer (loads only).
    - Go to IDLE. The same instruction is not re-triggered, because EXE2MEM advances on that edge.
- Stall cycles: while ready=0 the MEM/WB register loads a bubble: wb_en_out=0, mem_read_out=0; dest_out, alu_result_out and mem_data_out hold their values.
- Latency: a memory instruction holds the stage for WAIT_STATES+3 cycles (IDLE decision, ACCESS, DONE). ready is low for exactly WAIT_STATES+2 cycles.
- Back-to-back memory instructions: IDLE follows DONE, so each access pays the full latency. There is no pipelining of SRAM accesses.
- Store outputs to WB: wb_en_out passes wb_en_in unchanged; the decoder already clears it for STR.
- Timing: no combinational path from sram_dq_in to any output.

Test Plan:
- ALU-only stream: wb_en_in=1, dest_in=5, alu_result_in=0x1234 with no memory request -> ready stays 1; next cycle wb_en_out=1, dest_out=5, alu_result_out=0x1234; sram_we_n=1, sram_oe_n=1 throughout.
- Store, WAIT_STATES=3: mem_write_in=1, alu_result_in=1028, st_val_in=0xDEADBEEF -> sram_addr=1; sram_we_n low for exactly 4 cycles; ready low for 5 cycles, then high for 1 cycle; wb_en_out=0 during the stall cycles.
- Load after that store: mem_read_in=1, alu_result_in=1028, model returns 0xDEADBEEF -> after the DONE edge mem_read_out=1 and mem_data_out=0xDEADBEEF; sram_oe_n low for 4 cycles.
- Simultaneous read and write at alu_result_in=1024 -> write performed (sram_we_n low, sram_oe_n stays high); mem_read_out=0.
- Reset mid-access: assert rst=0 during the 2nd ACCESS cycle of a store -> immediately sram_we_n=1, ready=1, all outputs 0; after release, an ALU-only instruction completes in 1 cycle.
- Address wrap: alu_result_in=1024 + 4*65536 with ADDR_W=16 -> sram_addr=0; alu_result_in=1027 -> sram_addr=0 (low bits ignored).
